// File: rtl/datamem_ctrl_if.sv
// Pipeline-side and memory-side signals of the MEM-stage data memory controller.
// master is the controller's view; slave is the surrounding pipeline and memory.
interface datamem_ctrl_if;
  logic        memread;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    input  memread, memwrite, addr, wdata, mem_ack, mem_rdata,
    output rdata, stall, err, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output memread, memwrite, addr, wdata, mem_ack, mem_rdata,
    input  rdata, stall, err, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/datamem_ctrl.sv
// MEM-stage data memory controller: issues one word access per request, holds the
// pipeline while the memory is busy, and reports illegal requests and timeouts.
module datamem_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           reset,
  datamem_ctrl_if.master bus
);
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             one_op;
  logic             aligned;
  logic             go;
  logic             bad;
  logic             tmo;
  logic             stall;
  logic             err;
  logic             mem_req;
  logic             mem_we;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic [31:0]      rdata;

  assign one_op  = bus.memread ^ bus.memwrite;
  assign aligned = (bus.addr[1:0] == 2'b00);
  assign go      = one_op & aligned;
  assign bad     = (bus.memread & bus.memwrite) | (one_op & ~aligned);
  assign tmo     = (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (go) state_nxt = BUSY;
      BUSY:    if (bus.mem_ack || tmo) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The request cycle must freeze the pipeline combinationally, but never under reset.
  always_comb begin
    stall = 1'b0;
    case (state)
      IDLE:    stall = reset & go;
      BUSY:    stall = 1'b1;
      default: stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
      err       <= 1'b0;
      cnt       <= '0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            mem_addr  <= bus.addr;
            mem_wdata <= bus.wdata;
            mem_we    <= bus.memwrite;
            mem_req   <= 1'b1;
            cnt       <= '0;
          end else begin
            err <= bad;
          end
        end
        BUSY: begin
          // An ack in the timeout cycle still completes the access cleanly.
          if (bus.mem_ack) begin
            mem_req <= 1'b0;
            if (!mem_we) rdata <= bus.mem_rdata;
          end else if (tmo) begin
            mem_req <= 1'b0;
            err     <= 1'b1;
            if (!mem_we) rdata <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.stall     = stall;
  assign bus.err       = err;
  assign bus.rdata     = rdata;
  assign bus.mem_req   = mem_req;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
endmodule

// File: tb/tb_datamem_ctrl.sv
// Directed bench for datamem_ctrl: reads, writes, timeout, illegal requests,
// asynchronous reset mid-transaction and back-to-back requests.
module tb_datamem_ctrl;
  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   req_rises;

  datamem_ctrl_if bus ();

  datamem_ctrl #(.TIMEOUT(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial req_rises = 0;
  always @(posedge bus.mem_req) req_rises++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b0;
    bus.memread   = 1'b1;
    bus.memwrite  = 1'b0;
    bus.addr      = 32'h0;
    bus.wdata     = 32'h0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;

    // Reset state, stall forced low even with a valid request present
    #2;
    chk("rst_stall", bus.stall, 0);
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    tick();
    tick();

    // Read, ack two cycles after mem_req rises; first edge after release accepts it
    reset    = 1'b1;
    bus.addr = 32'h10;
    #1;
    chk("rd_req_stall", bus.stall, 1);
    tick();
    #1;
    chk("rd_busy_req", bus.mem_req, 1);
    chk("rd_busy_addr", bus.mem_addr, 32'h10);
    chk("rd_busy_we", bus.mem_we, 0);
    chk("rd_busy0_stall", bus.stall, 1);
    tick();
    #1;
    chk("rd_busy1_stall", bus.stall, 1);
    tick();
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hDEADBEEF;
    #1;
    chk("rd_busy2_stall", bus.stall, 1);
    chk("rd_busy2_req", bus.mem_req, 1);
    tick();
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
    #1;
    chk("rd_done_stall", bus.stall, 0);
    chk("rd_done_req", bus.mem_req, 0);
    chk("rd_done_rdata", bus.rdata, 32'hDEADBEEF);
    chk("rd_done_err", bus.err, 0);

    // Write follows immediately; the read still present in DONE is not re-issued
    tick();
    bus.memread  = 1'b0;
    bus.memwrite = 1'b1;
    bus.addr     = 32'h24;
    bus.wdata    = 32'h12345678;
    #1;
    chk("wr_idle_req", bus.mem_req, 0);
    chk("wr_req_stall", bus.stall, 1);
    tick();
    bus.mem_ack = 1'b1;
    #1;
    chk("wr_busy_we", bus.mem_we, 1);
    chk("wr_busy_wdata", bus.mem_wdata, 32'h12345678);
    chk("wr_busy_addr", bus.mem_addr, 32'h24);
    chk("wr_busy_stall", bus.stall, 1);
    tick();
    bus.mem_ack = 1'b0;
    #1;
    chk("wr_done_req", bus.mem_req, 0);
    chk("wr_done_rdata", bus.rdata, 32'hDEADBEEF);
    chk("wr_done_err", bus.err, 0);
    chk("wr_done_stall", bus.stall, 0);
    tick();
    bus.memwrite = 1'b0;
    bus.addr     = 32'h0;
    tick();
    #1;
    chk("b2b_req_count", req_rises, 2);
    chk("b2b_idle_req", bus.mem_req, 0);

    // Read with no ack: 16 cycles of mem_req, then err pulse and rdata cleared
    bus.memread = 1'b1;
    bus.addr    = 32'h40;
    tick();
    #1;
    chk("to_busy_req", bus.mem_req, 1);
    repeat (15) tick();
    #1;
    chk("to_last_req", bus.mem_req, 1);
    chk("to_last_err", bus.err, 0);
    chk("to_last_stall", bus.stall, 1);
    tick();
    #1;
    chk("to_done_err", bus.err, 1);
    chk("to_done_req", bus.mem_req, 0);
    chk("to_done_rdata", bus.rdata, 0);
    chk("to_done_stall", bus.stall, 0);
    tick();
    bus.memread = 1'b0;
    bus.addr    = 32'h0;
    #1;
    chk("to_err_pulse", bus.err, 0);
    chk("to_idle_req", bus.mem_req, 0);

    // Asynchronous reset in BUSY, then a stray ack after release
    bus.memread = 1'b1;
    bus.addr    = 32'h80;
    tick();
    #1;
    chk("ar_busy_req", bus.mem_req, 1);
    chk("ar_busy_wdata", bus.mem_wdata, 32'h12345678);
    #1;
    reset       = 1'b0;
    bus.memread = 1'b0;
    bus.addr    = 32'h0;
    #1;
    chk("ar_req", bus.mem_req, 0);
    chk("ar_addr", bus.mem_addr, 0);
    chk("ar_wdata", bus.mem_wdata, 0);
    chk("ar_stall", bus.stall, 0);
    tick();
    reset         = 1'b1;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hCAFEF00D;
    tick();
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
    #1;
    chk("ar_ack_rdata", bus.rdata, 0);
    chk("ar_ack_req", bus.mem_req, 0);
    chk("ar_ack_err", bus.err, 0);

    // Illegal requests: both strobes, then misaligned address
    bus.memread  = 1'b1;
    bus.memwrite = 1'b1;
    #1;
    chk("both_stall", bus.stall, 0);
    tick();
    bus.memwrite = 1'b0;
    bus.addr     = 32'h13;
    #1;
    chk("both_err", bus.err, 1);
    chk("both_req", bus.mem_req, 0);
    chk("mis_stall", bus.stall, 0);
    tick();
    bus.memread = 1'b0;
    bus.addr    = 32'h0;
    #1;
    chk("mis_err", bus.err, 1);
    chk("mis_req", bus.mem_req, 0);
    tick();
    #1;
    chk("mis_err_clear", bus.err, 0);
    chk("total_req_count", req_rises, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
